// File: rtl/pipe_reg_mw.sv
// MEM->WB pipeline register: DEPTH-stage chain with valid, stall/flush and writeback result mux.
// Optional macro PIPE_PERF_EN adds saturating stall/flush/retire counters.
module pipe_reg_mw #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [XLEN-1:0]   ResultW
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic [CNT_W-1:0]  RetireCnt
`endif
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_reg_mw: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic              v;
    logic              rw;
    logic [1:0]        rs;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   pc4;
  } stage_t;

  stage_t stg_q [DEPTH];
  stage_t stg_d [DEPTH];
  stage_t in_stage;
  logic   advance;

  assign advance = !FlushW && !StallW;

  // Bubbles enter as all-zero so invalid stages never carry stale data.
  always_comb begin
    in_stage = '0;
    if (ValidM) begin
      in_stage.v     = 1'b1;
      in_stage.rw    = RegWriteM;
      in_stage.rs    = ResultSrcM;
      in_stage.rd    = RdM;
      in_stage.alu   = ALUResultM;
      in_stage.rdata = ReadDataM;
      in_stage.pc4   = PCPlus4M;
    end
  end

  always_comb begin
    if (FlushW)      stg_d[0] = '0;
    else if (StallW) stg_d[0] = stg_q[0];
    else             stg_d[0] = in_stage;
    for (int i = 1; i < DEPTH; i++) begin
      if (FlushW)      stg_d[i] = '0;
      else if (StallW) stg_d[i] = stg_q[i];
      else             stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= stg_d[i];
    end
  end

  assign ValidW     = stg_q[DEPTH-1].v;
  assign RegWriteW  = stg_q[DEPTH-1].v && stg_q[DEPTH-1].rw && (stg_q[DEPTH-1].rd != '0);
  assign ResultSrcW = stg_q[DEPTH-1].rs;
  assign RdW        = stg_q[DEPTH-1].rd;
  assign ALUResultW = stg_q[DEPTH-1].alu;
  assign ReadDataW  = stg_q[DEPTH-1].rdata;
  assign PCPlus4W   = stg_q[DEPTH-1].pc4;

  always_comb begin
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (StallW && !FlushW && stall_cnt_q != '1) stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (FlushW && flush_cnt_q != '1)            flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (ValidW && advance && retire_cnt_q != '1) retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;
  assign RetireCnt = retire_cnt_q;
`endif

endmodule
